// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one cacheline pmem port between icache and dcache, round-robin on ties
//   clk, rst (async active-low)
//   icache_pmem_*  : icache line-fill request / fill data / done
//   dcache_pmem_*  : dcache fill or writeback request / fill data / done
//   pmem_*         : line-aligned request to physical memory and its response
module cache_mem_arbiter #(
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t            r_state, w_next;
    logic              r_last_d;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              w_ireq, w_dreq, w_grant_i, w_grant_d, w_idle;
    assign w_idle    = r_state == IDLE;
    assign w_ireq    = icache_pmem_read;
    assign w_dreq    = dcache_pmem_read | dcache_pmem_write;
    // on a tie the side that was not granted last wins
    assign w_grant_i = w_idle & w_ireq & (~w_dreq | r_last_d);
    assign w_grant_d = w_idle & w_dreq & (~w_ireq | ~r_last_d);
    always_comb begin
        w_next = r_state;
        if (w_idle)
            w_next = w_grant_i ? SERVE_I : w_grant_d ? SERVE_D : IDLE;
        else if (pmem_resp)
            w_next = IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_i) begin
                r_last_d <= 1'b0;
                r_write  <= 1'b0;
                r_addr   <= {icache_pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                r_wdata  <= '0;
            end else if (w_grant_d) begin
                r_last_d <= 1'b1;
                // read+write together is tolerated; the writeback wins
                r_write  <= dcache_pmem_write;
                r_addr   <= {dcache_pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                r_wdata  <= dcache_pmem_wdata;
            end
        end
    end
    assign pmem_read         = ~w_idle & ~r_write;
    assign pmem_write        = ~w_idle & r_write;
    assign pmem_address      = r_addr;
    assign pmem_wdata        = r_wdata;
    assign icache_pmem_resp  = (r_state == SERVE_I) & pmem_resp;
    assign dcache_pmem_resp  = (r_state == SERVE_D) & pmem_resp;
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    logic         clk = 0;
    logic         rst = 0;
    logic         icache_pmem_read = 0;
    logic [31:0]  icache_pmem_address = 0;
    logic [255:0] icache_pmem_rdata;
    logic         icache_pmem_resp;
    logic         dcache_pmem_read = 0;
    logic         dcache_pmem_write = 0;
    logic [31:0]  dcache_pmem_address = 0;
    logic [255:0] dcache_pmem_wdata = 0;
    logic [255:0] dcache_pmem_rdata;
    logic         dcache_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = 0;
    logic         pmem_resp = 0;
    int tests = 0;
    int fails = 0;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
        .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
        .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
        .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic edge_drive;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 0;
        edge_drive();
        edge_drive();
        rst = 1;
        edge_drive();
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl got=%b exp=0000", {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp});
        end
        tests++;
        if (pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
            fails++;
            $display("FAIL reset_regs addr=%h wdata=%h exp=0", pmem_address, pmem_wdata);
        end
        rst = 1;
        edge_drive();
    endtask

    task automatic test_icache_read;
        logic [255:0] exp_rd;
        exp_rd = {32{8'hAA}};
        icache_pmem_read = 1;
        icache_pmem_address = 32'h0000_1234;
        @(negedge clk);
        tests++;
        if (pmem_read !== 1'b0) begin
            fails++;
            $display("FAIL icache_latency pmem_read=%b exp=0", pmem_read);
        end
        for (int i = 0; i < 4; i++) begin
            edge_drive();
            @(negedge clk);
            tests++;
            if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_1220 || icache_pmem_resp !== 1'b0) begin
                fails++;
                $display("FAIL icache_req cyc=%0d rd=%b wr=%b addr=%h iresp=%b exp rd=1 wr=0 addr=00001220 iresp=0",
                         i, pmem_read, pmem_write, pmem_address, icache_pmem_resp);
            end
        end
        edge_drive();
        pmem_resp = 1;
        pmem_rdata = exp_rd;
        @(negedge clk);
        tests++;
        if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0 || icache_pmem_rdata !== exp_rd) begin
            fails++;
            $display("FAIL icache_resp iresp=%b dresp=%b rdata=%h exp iresp=1 dresp=0 rdata=%h",
                     icache_pmem_resp, dcache_pmem_resp, icache_pmem_rdata, exp_rd);
        end
        tests++;
        if (dcache_pmem_rdata !== exp_rd) begin
            fails++;
            $display("FAIL rdata_fwd_d got=%h exp=%h", dcache_pmem_rdata, exp_rd);
        end
        edge_drive();
        pmem_resp = 0;
        icache_pmem_read = 0;
        @(negedge clk);
        tests++;
        if (pmem_read !== 1'b0 || icache_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL icache_done rd=%b iresp=%b exp 0 0", pmem_read, icache_pmem_resp);
        end
    endtask

    task automatic test_dcache_write;
        logic [255:0] wd;
        wd = {8{32'hDEAD_BEEF}};
        edge_drive();
        dcache_pmem_write = 1;
        dcache_pmem_address = 32'h8000_0040;
        dcache_pmem_wdata = wd;
        edge_drive();
        dcache_pmem_wdata = '1;
        @(negedge clk);
        tests++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h8000_0040 || pmem_wdata !== wd) begin
            fails++;
            $display("FAIL dcache_write wr=%b rd=%b addr=%h wdata=%h exp wr=1 rd=0 addr=80000040 wdata=%h",
                     pmem_write, pmem_read, pmem_address, pmem_wdata, wd);
        end
        edge_drive();
        edge_drive();
        @(negedge clk);
        tests++;
        if (pmem_wdata !== wd || pmem_write !== 1'b1) begin
            fails++;
            $display("FAIL dcache_hold wdata=%h wr=%b exp wdata=%h wr=1", pmem_wdata, pmem_write, wd);
        end
        edge_drive();
        pmem_resp = 1;
        @(negedge clk);
        tests++;
        if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL dcache_resp dresp=%b iresp=%b exp 1 0", dcache_pmem_resp, icache_pmem_resp);
        end
        edge_drive();
        pmem_resp = 0;
        dcache_pmem_write = 0;
        @(negedge clk);
        tests++;
        if (pmem_write !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL dcache_done wr=%b dresp=%b exp 0 0", pmem_write, dcache_pmem_resp);
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_a;
        do_reset();
        icache_pmem_read = 1;
        icache_pmem_address = 32'h0000_0100;
        dcache_pmem_read = 1;
        dcache_pmem_address = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            exp_a = (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
            edge_drive();
            @(negedge clk);
            tests++;
            if (pmem_read !== 1'b1 || pmem_address !== exp_a) begin
                fails++;
                $display("FAIL rr_grant k=%0d rd=%b addr=%h exp rd=1 addr=%h", k, pmem_read, pmem_address, exp_a);
            end
            edge_drive();
            pmem_resp = 1;
            @(negedge clk);
            tests++;
            if (icache_pmem_resp !== (k % 2 == 1) || dcache_pmem_resp !== (k % 2 == 0)) begin
                fails++;
                $display("FAIL rr_resp k=%0d iresp=%b dresp=%b exp iresp=%b dresp=%b",
                         k, icache_pmem_resp, dcache_pmem_resp, k % 2 == 1, k % 2 == 0);
            end
            edge_drive();
            pmem_resp = 0;
            @(negedge clk);
            tests++;
            if (pmem_read !== 1'b0) begin
                fails++;
                $display("FAIL rr_idle k=%0d rd=%b exp=0", k, pmem_read);
            end
        end
        icache_pmem_read = 0;
        dcache_pmem_read = 0;
        edge_drive();
    endtask

    task automatic test_read_write_both;
        dcache_pmem_read = 1;
        dcache_pmem_write = 1;
        dcache_pmem_address = 32'h0000_0400;
        edge_drive();
        @(negedge clk);
        tests++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
            fails++;
            $display("FAIL rw_both wr=%b rd=%b exp wr=1 rd=0", pmem_write, pmem_read);
        end
        edge_drive();
        pmem_resp = 1;
        edge_drive();
        pmem_resp = 0;
        dcache_pmem_read = 0;
        dcache_pmem_write = 0;
        edge_drive();
    endtask

    task automatic test_reset_mid;
        icache_pmem_read = 1;
        icache_pmem_address = 32'h0000_0800;
        edge_drive();
        @(negedge clk);
        tests++;
        if (pmem_read !== 1'b1) begin
            fails++;
            $display("FAIL mid_serve rd=%b exp=1", pmem_read);
        end
        edge_drive();
        rst = 0;
        icache_pmem_read = 0;
        #1;
        tests++;
        if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0 || pmem_address !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset ctrl=%b addr=%h exp ctrl=0000 addr=0",
                     {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp}, pmem_address);
        end
        edge_drive();
        rst = 1;
        edge_drive();
        pmem_resp = 1;
        @(negedge clk);
        tests++;
        if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0) begin
            fails++;
            $display("FAIL late_resp ctrl=%b exp=0000", {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp});
        end
        edge_drive();
        pmem_resp = 0;
    endtask

    task automatic test_spurious_resp;
        edge_drive();
        pmem_resp = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0) begin
                fails++;
                $display("FAIL spurious cyc=%0d ctrl=%b exp=0000", i, {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp});
            end
            edge_drive();
        end
        pmem_resp = 0;
    endtask

    initial begin
        #2;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_round_robin();
        test_read_write_both();
        test_reset_mid();
        test_spurious_resp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
